// File: rtl/serial_adder_ctrl_if.sv
// Start/operand request and Busy/Done/result response bundle
// for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output Start, A, B, Cin,
    input  Busy, Done, Sum, Cout
  );

  modport slave (
    input  Start, A, B, Cin,
    output Busy, Done, Sum, Cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder cell, LSB first,
// carry held in a flop between bits, registered Sum/Cout with Done pulse.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             last;
  logic [WIDTH-1:0] acc_nx;

  full_adder u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt_q == LAST);
  // shift form stays legal at WIDTH=1
  assign acc_nx = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = ADD;
      ADD:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE) && bus.Start: begin
        opa_d   = bus.A;
        opb_d   = bus.B;
        carry_d = bus.Cin;
        acc_d   = '0;
        cnt_d   = '0;
      end
      (state_q == ADD): begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = acc_nx;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d  = acc_nx;
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.Busy = (state_q == ADD);
    bus.Done = (state_q == DONE);
    bus.Sum  = sum_q;
    bus.Cout = cout_q;
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised bench for serial_adder_ctrl at WIDTH=8 and
// WIDTH=1, checked against plain A+B+Cin arithmetic and cycle timing.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] prev8 = '0;
  logic [1:0] prev1 = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) i1 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (i8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (i1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench sampling inside the Done cycle.
  task automatic add8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input bit from_done,
                      input bit disturb);
    int         lat;
    int         busy;
    bit         held;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    i8.A = a;
    i8.B = b;
    i8.Cin = c;
    i8.Start = 1'b1;
    if (from_done) begin
      tick();
      chk("start_in_done8", {i8.Busy, i8.Done}, 2'b00);
    end
    tick();
    i8.Start = 1'b0;
    lat = 0;
    busy = 0;
    held = 1'b1;
    while (!i8.Done && lat < 40) begin
      if (disturb && lat == 3) begin
        i8.Start = 1'b1;
        i8.A = 8'hAA;
        i8.B = 8'h55;
      end else if (disturb && lat == 4) begin
        i8.Start = 1'b0;
      end
      if (i8.Busy) busy++;
      if ({i8.Cout, i8.Sum} !== prev8) held = 1'b0;
      tick();
      lat++;
    end
    chk("latency8", 64'(lat), 64'd8);
    chk("busy8", 64'(busy), 64'd8);
    chk("hold8", 64'(held), 64'd1);
    chk("result8", {i8.Cout, i8.Sum}, exp);
    prev8 = exp;
  endtask

  task automatic add1(input logic a, input logic b, input logic c,
                      input bit from_done);
    int         lat;
    int         busy;
    bit         held;
    logic [1:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
    i1.A = a;
    i1.B = b;
    i1.Cin = c;
    i1.Start = 1'b1;
    if (from_done) begin
      tick();
      chk("start_in_done1", {i1.Busy, i1.Done}, 2'b00);
    end
    tick();
    i1.Start = 1'b0;
    lat = 0;
    busy = 0;
    held = 1'b1;
    while (!i1.Done && lat < 20) begin
      if (i1.Busy) busy++;
      if ({i1.Cout, i1.Sum} !== prev1) held = 1'b0;
      tick();
      lat++;
    end
    chk("latency1", 64'(lat), 64'd1);
    chk("busy1", 64'(busy), 64'd1);
    chk("hold1", 64'(held), 64'd1);
    chk("result1", {i1.Cout, i1.Sum}, exp);
    prev1 = exp;
  endtask

  initial begin
    int         ndone;
    int         nbusy;
    int         last;
    logic [7:0] ra, rb;
    logic       rc;

    rst_n = 1'b0;
    i8.Start = 1'b0;
    i8.A = '0;
    i8.B = '0;
    i8.Cin = 1'b0;
    i1.Start = 1'b0;
    i1.A = '0;
    i1.B = '0;
    i1.Cin = 1'b0;
    #3;
    chk("reset8", {i8.Busy, i8.Done, i8.Cout, i8.Sum}, 64'd0);
    chk("reset1", {i1.Busy, i1.Done, i1.Cout, i1.Sum}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle8", {i8.Busy, i8.Done}, 2'b00);

    add8(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick();
    chk("done_width", 64'(i8.Done), 64'd0);
    chk("sum_holds_idle", {i8.Cout, i8.Sum}, 9'h096);
    add8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    add8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();

    add8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (i8.Done) ndone++;
      if (i8.Busy) nbusy++;
    end
    chk("extra_done", 64'(ndone), 64'd0);
    chk("extra_busy", 64'(nbusy), 64'd0);
    chk("disturb_sum", {i8.Cout, i8.Sum}, 9'h002);

    i8.A = 8'h77;
    i8.B = 8'h11;
    i8.Start = 1'b1;
    tick();
    i8.Start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {i8.Busy, i8.Done, i8.Cout, i8.Sum}, 64'd0);
    prev8 = '0;
    prev1 = '0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("abort_idle", {i8.Busy, i8.Done}, 2'b00);
    add8(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();

    i8.A = 8'h81;
    i8.B = 8'h92;
    i8.Cin = 1'b1;
    i8.Start = 1'b1;
    tick();
    ndone = 0;
    last = -1;
    for (int idx = 0; idx < 40; idx++) begin
      if (i8.Done) begin
        ndone++;
        chk("b2b_first", 64'(last < 0 ? idx : 8), 64'd8);
        if (last >= 0) chk("b2b_spacing", 64'(idx - last), 64'd10);
        chk("b2b_sum", {i8.Cout, i8.Sum}, 9'h114);
        last = idx;
      end
      if (idx < 39) tick();
    end
    chk("b2b_count", 64'(ndone), 64'd4);
    i8.Start = 1'b0;
    tick();
    chk("b2b_stop", {i8.Busy, i8.Done}, 2'b00);
    prev8 = 9'h114;

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8(ra, rb, rc, i > 0, 1'b0);
    end
    tick();

    for (int i = 0; i < 1000; i++) begin
      add1(1'($urandom), 1'($urandom), 1'($urandom), i > 0);
    end
    tick();
    chk("final_idle1", {i1.Busy, i1.Done}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
